// File: rtl/matrix_stream_loader.sv
// Purpose : assemble a row-major element stream into a packed ROWS x COLS matrix bus.
// Latency : the final beat at edge N gives mat_valid=1 after edge N. The minimum period is ROWS*COLS+1 cycles (single bank).
// Backpr. : in_ready drops while no bank is free to fill. The consumer releases a matrix with mat_ack.
// Ports   : clk, rst_n (async active-low) | in_data/in_valid/in_last/in_ready element stream |
//           mat_out/mat_valid/mat_ack matrix handshake | err_len one-cycle stream length error pulse.
// Config  : LOADER_DBUF_EN selects a ping-pong pair of fill banks. Without it there is a single FILL/FULL bank.
module matrix_stream_loader #(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int bitlength = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [bitlength-1:0]          in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [ROWS*COLS*bitlength-1:0] mat_out,
  output logic                          mat_valid,
  input  logic                          mat_ack,
  output logic                          err_len
);

  localparam int N    = ROWS * COLS;
  localparam int MW   = N * bitlength;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  logic [IDXW-1:0] idx;
  logic            beat;
  logic            fin;
  logic [MW-1:0]   fill_bank;
  logic [MW-1:0]   fill_nxt;

  assign beat = in_valid && in_ready;
  assign fin  = beat && (idx == LAST);

  // The completed matrix includes the element arriving on the final beat.
  // It can therefore be published on the same edge.
  always_comb begin
    fill_nxt = fill_bank;
    fill_nxt[int'(idx)*bitlength +: bitlength] = in_data;
  end

  // Element counter and length checking. An early in_last discards the partial matrix.
  // A final beat without in_last still publishes the matrix, but it is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= beat && (in_last != (idx == LAST));
      if (beat) begin
        if (fin || in_last) idx <= '0;
        else                idx <= idx + 1'b1;
      end
    end
  end

`ifdef LOADER_DBUF_EN
  logic [1:0][MW-1:0] bank;
  logic [1:0]         full;
  logic [1:0]         full_n;
  logic               wr_sel;
  logic               rd_sel;
  logic               rd_n;
  logic               ack;

  assign ack       = mat_ack && mat_valid;
  assign fill_bank = bank[wr_sel];

  always_comb begin
    full_n = full;
    if (ack) full_n[rd_sel] = 1'b0;
    if (fin) full_n[wr_sel] = 1'b1;
    rd_n = rd_sel ^ ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank      <= '0;
      full      <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      mat_out   <= '0;
      mat_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (beat) bank[wr_sel][int'(idx)*bitlength +: bitlength] <= in_data;
      if (fin) wr_sel <= ~wr_sel;
      full      <= full_n;
      rd_sel    <= rd_n;
      mat_valid <= full_n[rd_n];
      in_ready  <= ~&full_n;
      // mat_out is a separate register, loaded only when a new matrix becomes the oldest complete one.
      // A bank that is still filling therefore never reaches the output.
      if (fin && (!mat_valid || ack))
        mat_out <= fill_nxt;
      else if (ack && full[~rd_sel])
        mat_out <= bank[~rd_sel];
    end
  end
`else
  typedef enum logic {FILL, FULL} state_t;
  state_t        state;
  logic [MW-1:0] bank;

  assign fill_bank = bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      bank      <= '0;
      mat_out   <= '0;
      mat_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (beat) bank[int'(idx)*bitlength +: bitlength] <= in_data;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (fin) begin
            state     <= FULL;
            mat_valid <= 1'b1;
            in_ready  <= 1'b0;
            mat_out   <= fill_nxt;
          end
        end
        FULL: begin
          if (mat_ack) begin
            state     <= FILL;
            mat_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_matrix_stream_loader.sv
module tb_matrix_stream_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [71:0] mat_out;
  logic        mat_valid;
  logic        mat_ack;
  logic        err_len;

  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_last;
  logic        b_ready;
  logic [71:0] b_mat;
  logic        b_mvalid;
  logic        b_ack;
  logic        b_err;

  int errors = 0;
  int checks = 0;

  matrix_stream_loader #(.ROWS(3), .COLS(3), .bitlength(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mat_out(mat_out), .mat_valid(mat_valid), .mat_ack(mat_ack),
    .err_len(err_len)
  );

  matrix_stream_loader #(.ROWS(3), .COLS(3), .bitlength(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_ready), .mat_out(b_mat), .mat_valid(b_mvalid), .mat_ack(b_ack),
    .err_len(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       last;
    logic       ack;
    logic       e_rdy;
    logic       e_mv;
    logic       e_err;
    logic [7:0] e0;
    logic [7:0] e4;
    logic [7:0] e8;
  } vec_t;

  vec_t tbl[$];

  logic [7:0] av[9] = '{8'd3, 8'd4, 8'd5, 8'd5, 8'd6, 8'd7, 8'd7, 8'd8, 8'd9};
  logic [7:0] bv[9] = '{8'd4, 8'd5, 8'd6, 8'd6, 8'd7, 8'd8, 8'd8, 8'd9, 8'd10};

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] elem(input logic [71:0] m, input int k);
    return m[k*8 +: 8];
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic a,
                     input logic r, input logic mv, input logic er,
                     input logic [7:0] e0, input logic [7:0] e4, input logic [7:0] e8);
    vec_t t;
    t.vld = v; t.dat = d; t.last = l; t.ack = a;
    t.e_rdy = r; t.e_mv = mv; t.e_err = er; t.e0 = e0; t.e4 = e4; t.e8 = e8;
    tbl.push_back(t);
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    logic [71:0] held;
    int c11, c33;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; mat_ack = 1'b0;
    b_data = '0; b_valid = 1'b0; b_last = 1'b0; b_ack = 1'b0;

    // Reset state
    #11;
    chk("reset mat_out", mat_out, 72'h0);
    chk("reset mat_valid", mat_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset err_len", err_len, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after release", in_ready, 1);

`ifndef LOADER_DBUF_EN
    // Basic fill 1..9, then a stray beat while full that must be ignored during the ack.
    for (int k = 1; k <= 8; k++) add(1, 8'(k), 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    add(1, 8'd9, 1, 0, 0, 1, 0, 8'd1, 8'd5, 8'd9);
    add(0, 8'd0, 0, 0, 0, 1, 0, 8'd1, 8'd5, 8'd9);
    add(1, 8'hAA, 1, 1, 1, 0, 0, 8'd1, 8'd5, 8'd9);
    // in_last arrives early on beat 4: the partial matrix is dropped and err_len pulses once.
    add(1, 8'h20, 0, 0, 1, 0, 0, 8'd1, 8'd5, 8'd9);
    add(1, 8'h21, 0, 0, 1, 0, 0, 8'd1, 8'd5, 8'd9);
    add(1, 8'h22, 0, 0, 1, 0, 0, 8'd1, 8'd5, 8'd9);
    add(1, 8'h23, 1, 0, 1, 0, 1, 8'd1, 8'd5, 8'd9);
    for (int k = 10; k <= 17; k++) add(1, 8'(k), 0, 0, 1, 0, 0, 8'd1, 8'd5, 8'd9);
    add(1, 8'd18, 1, 0, 0, 1, 0, 8'd10, 8'd14, 8'd18);
    add(0, 8'd0, 0, 1, 1, 0, 0, 8'd10, 8'd14, 8'd18);
    add(0, 8'd0, 0, 1, 1, 0, 0, 8'd10, 8'd14, 8'd18);
    // The final beat arrives without in_last: the matrix is still published, together with err_len.
    for (int k = 0; k < 8; k++) add(1, 8'h30 + 8'(k), 0, 0, 1, 0, 0, 8'd10, 8'd14, 8'd18);
    add(1, 8'h38, 0, 0, 0, 1, 1, 8'h30, 8'h34, 8'h38);
    add(0, 8'd0, 0, 0, 0, 1, 0, 8'h30, 8'h34, 8'h38);
    add(0, 8'd0, 0, 1, 1, 0, 0, 8'h30, 8'h34, 8'h38);

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].vld; in_data = tbl[i].dat; in_last = tbl[i].last; mat_ack = tbl[i].ack;
      @(posedge clk); #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d mat_valid", i), mat_valid, tbl[i].e_mv);
      chk($sformatf("vec%0d err_len", i), err_len, tbl[i].e_err);
      chk($sformatf("vec%0d elem0", i), elem(mat_out, 0), tbl[i].e0);
      chk($sformatf("vec%0d elem4", i), elem(mat_out, 4), tbl[i].e4);
      chk($sformatf("vec%0d elem8", i), elem(mat_out, 8), tbl[i].e8);
    end
    in_valid = 1'b0; in_last = 1'b0; mat_ack = 1'b0;

    // Hold the full matrix for 20 cycles while garbage is offered on the input.
    held = '0;
    for (int k = 0; k < 9; k++) begin
      held[k*8 +: 8] = 8'h60 + 8'(k);
      beat(8'h60 + 8'(k), k == 8);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold%0d in_ready", c), in_ready, 0);
      chk($sformatf("hold%0d mat_out", c), mat_out, held);
    end
    in_valid = 1'b0; in_last = 1'b0; mat_ack = 1'b1;
    @(posedge clk); #1;
    mat_ack = 1'b0;
    chk("hold release in_ready", in_ready, 1);
    chk("hold release mat_valid", mat_valid, 0);
    chk("hold release err_len", err_len, 0);
    chk("hold release mat_out", mat_out, held);
`else
    // Stream three matrices back to back. M1 is acked mid-stream, and M2 is acked on the final beat of M3.
    for (int k = 1; k <= 27; k++) begin
      in_valid = 1'b1; in_data = 8'(k); in_last = (k % 9 == 0);
      mat_ack = (k == 12 || k == 27);
      @(posedge clk); #1;
      chk($sformatf("dbuf%0d in_ready", k), in_ready, 1);
      chk($sformatf("dbuf%0d mat_valid", k), mat_valid, (k >= 9 && k < 12) || k >= 18);
      if (k >= 27)      chk($sformatf("dbuf%0d elem0", k), elem(mat_out, 0), 8'd19);
      else if (k >= 18) chk($sformatf("dbuf%0d elem0", k), elem(mat_out, 0), 8'd10);
      else if (k < 12 && k >= 9) chk($sformatf("dbuf%0d elem0", k), elem(mat_out, 0), 8'd1);
    end
    mat_ack = 1'b0;
    // Fill M4 without an ack, so that both banks are full.
    for (int k = 28; k <= 36; k++) beat(8'(k), k == 36);
    chk("dbuf both full in_ready", in_ready, 0);
    chk("dbuf both full elem0", elem(mat_out, 0), 8'd19);
    beat(8'hEE, 1'b1);
    chk("dbuf ignored beat err_len", err_len, 0);
    mat_ack = 1'b1;
    @(posedge clk); #1;
    mat_ack = 1'b0;
    chk("dbuf after ack in_ready", in_ready, 1);
    chk("dbuf after ack mat_valid", mat_valid, 1);
    chk("dbuf after ack elem0", elem(mat_out, 0), 8'd28);
    chk("dbuf after ack elem8", elem(mat_out, 8), 8'd36);
    mat_ack = 1'b1;
    @(posedge clk); #1;
    mat_ack = 1'b0;
    chk("dbuf drained mat_valid", mat_valid, 0);
`endif

    // Reset in the middle of a fill: everything is discarded and the next matrix starts clean.
    for (int k = 0; k < 5; k++) beat(8'h70 + 8'(k), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midfill reset mat_out", mat_out, 72'h0);
    chk("midfill reset mat_valid", mat_valid, 0);
    chk("midfill reset in_ready", in_ready, 0);
    chk("midfill reset err_len", err_len, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerelease in_ready", in_ready, 1);
    for (int k = 0; k < 9; k++) beat(8'h80 + 8'(k), k == 8);
    chk("fresh mat_valid", mat_valid, 1);
    chk("fresh elem0", elem(mat_out, 0), 8'h80);
    chk("fresh elem8", elem(mat_out, 8), 8'h88);
    chk("fresh err_len", err_len, 0);
    mat_ack = 1'b1;
    @(posedge clk); #1;
    mat_ack = 1'b0;
    chk("fresh ack mat_valid", mat_valid, 0);

    // Two loaders feed the operands of a 3x3 product.
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; in_data = av[k]; in_last = (k == 8);
      b_valid  = 1'b1; b_data  = bv[k]; b_last  = (k == 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    chk("mul A mat_valid", mat_valid, 1);
    chk("mul B mat_valid", b_mvalid, 1);
    c11 = 0; c33 = 0;
    for (int k = 0; k < 3; k++) begin
      c11 += int'(elem(mat_out, k)) * int'(elem(b_mat, k*3));
      c33 += int'(elem(mat_out, 6 + k)) * int'(elem(b_mat, k*3 + 2));
    end
    // Row 1 of A times column 1 of B: 3*4 + 4*6 + 5*8 = 76.
    // Row 3 of A times column 3 of B: 7*6 + 8*8 + 9*10 = 196.
    chk("mul C11", 72'(c11), 72'd76);
    chk("mul C33", 72'(c33), 72'd196);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
